// File: rtl/load_store_unit_if.sv
// Execute/data-memory/write-back signal bundle for load_store_unit.
// Signal names carry the LSU's point of view: i_ = into the unit, o_ = out of it.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [XLEN-1:0]   i_req_addr;
  logic [XLEN-1:0]   i_req_wdata;
  logic              o_dm_avalid;
  logic              i_dm_aready;
  logic [XLEN-1:0]   o_dm_addr;
  logic              o_dm_we;
  logic [XLEN/8-1:0] o_dm_wstrb;
  logic [XLEN-1:0]   o_dm_wdata;
  logic              i_dm_rvalid;
  logic [XLEN-1:0]   i_dm_rdata;
  logic              o_rsp_valid;
  logic [XLEN-1:0]   o_rsp_rdata;
  logic              o_rsp_fault;

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
           i_dm_aready, i_dm_rvalid, i_dm_rdata,
    output o_req_ready, o_dm_avalid, o_dm_addr, o_dm_we, o_dm_wstrb, o_dm_wdata,
           o_rsp_valid, o_rsp_rdata, o_rsp_fault
  );

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
           i_dm_aready, i_dm_rvalid, i_dm_rdata,
    input  o_req_ready, o_dm_avalid, o_dm_addr, o_dm_we, o_dm_wstrb, o_dm_wdata,
           o_rsp_valid, o_rsp_rdata, o_rsp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: aligns stores onto byte lanes, extracts and
// extends loads, and reports misaligned/illegal requests without touching memory.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  load_store_unit_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RWAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_rsp_valid;
  logic            r_rsp_fault;
  logic [XLEN-1:0] r_rsp_rdata;

  logic            w_accept;
  logic            w_f3_ok;
  logic            w_misaligned;
  logic            w_req_fault;
  logic            w_rsp_set;
  logic            w_rsp_fault_set;
  logic [XLEN-1:0] w_rsp_rdata_nxt;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_ext;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  assign w_accept = bus.i_req_valid && (r_state == S_IDLE);

  // Illegal funct3 dominates; alignment only matters for H/HU and W widths.
  always_comb begin
    if (bus.i_req_we)
      w_f3_ok = (bus.i_req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_f3_ok = (bus.i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misaligned = ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) ||
                   ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));
    w_req_fault  = !w_f3_ok || w_misaligned;
  end

  always_comb begin
    w_wstrb = '0;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: w_wstrb = 4'b1111;
    endcase
    if (!r_we) w_wstrb = '0;
  end

  assign w_shifted = bus.i_dm_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_set       = 1'b0;
    w_rsp_fault_set = 1'b0;
    w_rsp_rdata_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          if (w_req_fault) begin
            w_rsp_set       = 1'b1;
            w_rsp_fault_set = 1'b1;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.i_dm_aready) begin
          if (r_we) begin
            w_state_nxt = S_IDLE;
            w_rsp_set   = 1'b1;
          end else begin
            w_state_nxt = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        if (bus.i_dm_rvalid) begin
          w_state_nxt     = S_IDLE;
          w_rsp_set       = 1'b1;
          w_rsp_rdata_nxt = w_load_ext;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.i_req_we;
        r_funct3 <= bus.i_req_funct3;
        r_addr   <= bus.i_req_addr;
        r_wdata  <= bus.i_req_wdata;
      end
      r_rsp_valid <= w_rsp_set;
      r_rsp_fault <= w_rsp_fault_set;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign bus.o_req_ready = (r_state == S_IDLE);
  assign bus.o_dm_avalid = (r_state == S_ADDR);
  assign bus.o_dm_addr   = {r_addr[XLEN-1:2], 2'b00};
  assign bus.o_dm_we     = r_we;
  assign bus.o_dm_wstrb  = w_wstrb;
  assign bus.o_dm_wdata  = w_wdata;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_fault = r_rsp_fault;
  assign bus.o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, lane-extracted loads, faults,
// back-to-back acceptance and asynchronous reset during a load.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs then show the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata);
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input int unsigned rdelay, input logic [31:0] exp);
    req(1'b0, f3, addr, 32'h0);
    step();
    chk({tag, ".avalid"}, 32'(bus.o_dm_avalid), 32'd1);
    chk({tag, ".we"}, 32'(bus.o_dm_we), 32'd0);
    chk({tag, ".wstrb"}, 32'(bus.o_dm_wstrb), 32'h0);
    chk({tag, ".addr"}, bus.o_dm_addr, {addr[31:2], 2'b00});
    bus.i_req_valid = 1'b0;
    bus.i_dm_aready = 1'b1;
    step();
    bus.i_dm_aready = 1'b0;
    chk({tag, ".avalid_drop"}, 32'(bus.o_dm_avalid), 32'd0);
    for (int unsigned i = 0; i < rdelay; i++) begin
      step();
      chk({tag, ".no_early_rsp"}, 32'(bus.o_rsp_valid), 32'd0);
    end
    bus.i_dm_rvalid = 1'b1;
    bus.i_dm_rdata  = 32'h12F4_5678;
    step();
    bus.i_dm_rvalid = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
    chk({tag, ".rsp_fault"}, 32'(bus.o_rsp_fault), 32'd0);
    chk({tag, ".rsp_rdata"}, bus.o_rsp_rdata, exp);
    step();
    chk({tag, ".rsp_single"}, 32'(bus.o_rsp_valid), 32'd0);
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    req(we, f3, addr, 32'hFFFF_FFFF);
    step();
    bus.i_req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
    chk({tag, ".rsp_fault"}, 32'(bus.o_rsp_fault), 32'd1);
    chk({tag, ".rsp_rdata"}, bus.o_rsp_rdata, 32'h0);
    chk({tag, ".avalid"}, 32'(bus.o_dm_avalid), 32'd0);
    chk({tag, ".ready"}, 32'(bus.o_req_ready), 32'd1);
    step();
    chk({tag, ".rsp_single"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({tag, ".avalid_after"}, 32'(bus.o_dm_avalid), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_req_addr   = '0;
    bus.i_req_wdata  = '0;
    bus.i_dm_aready  = 1'b0;
    bus.i_dm_rvalid  = 1'b0;
    bus.i_dm_rdata   = '0;

    #12;
    chk("rst.ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst.avalid", 32'(bus.o_dm_avalid), 32'd0);
    chk("rst.rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst.rsp_fault", 32'(bus.o_rsp_fault), 32'd0);
    chk("rst.rsp_rdata", bus.o_rsp_rdata, 32'h0);
    chk("rst.addr", bus.o_dm_addr, 32'h0);
    chk("rst.wstrb", 32'(bus.o_dm_wstrb), 32'h0);
    chk("rst.wdata", bus.o_dm_wdata, 32'h0);
    chk("rst.we", 32'(bus.o_dm_we), 32'd0);
    rst_n = 1'b1;
    step();

    // SW, aready already high in N+1
    req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    bus.i_dm_aready = 1'b1;
    step();
    bus.i_req_valid = 1'b0;
    chk("sw.avalid", 32'(bus.o_dm_avalid), 32'd1);
    chk("sw.addr", bus.o_dm_addr, 32'h0000_0100);
    chk("sw.we", 32'(bus.o_dm_we), 32'd1);
    chk("sw.wstrb", 32'(bus.o_dm_wstrb), 32'hF);
    chk("sw.wdata", bus.o_dm_wdata, 32'hDEAD_BEEF);
    chk("sw.ready", 32'(bus.o_req_ready), 32'd0);
    chk("sw.no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    step();
    bus.i_dm_aready = 1'b0;
    chk("sw.rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("sw.rsp_fault", 32'(bus.o_rsp_fault), 32'd0);
    chk("sw.rsp_rdata", bus.o_rsp_rdata, 32'h0);
    chk("sw.avalid_drop", 32'(bus.o_dm_avalid), 32'd0);
    chk("sw.ready_back", 32'(bus.o_req_ready), 32'd1);
    step();

    // SB to lane 3 with aready low for 3 cycles
    req(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56A5);
    step();
    bus.i_req_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("sb.avalid", 32'(bus.o_dm_avalid), 32'd1);
      chk("sb.addr", bus.o_dm_addr, 32'h0000_0100);
      chk("sb.wstrb", 32'(bus.o_dm_wstrb), 32'h8);
      chk("sb.wdata", bus.o_dm_wdata, 32'hA5A5_A5A5);
      chk("sb.no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      if (i == 3) bus.i_dm_aready = 1'b1;
      step();
    end
    bus.i_dm_aready = 1'b0;
    chk("sb.rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("sb.rsp_fault", 32'(bus.o_rsp_fault), 32'd0);
    chk("sb.avalid_drop", 32'(bus.o_dm_avalid), 32'd0);
    step();
    chk("sb.rsp_single", 32'(bus.o_rsp_valid), 32'd0);

    // SH to upper half: lanes 2-3, data replicated
    req(1'b1, 3'b001, 32'h0000_0206, 32'hAAAA_BEEF);
    step();
    bus.i_req_valid = 1'b0;
    chk("sh.wstrb", 32'(bus.o_dm_wstrb), 32'hC);
    chk("sh.wdata", bus.o_dm_wdata, 32'hBEEF_BEEF);
    chk("sh.addr", bus.o_dm_addr, 32'h0000_0204);
    bus.i_dm_aready = 1'b1;
    step();
    bus.i_dm_aready = 1'b0;
    chk("sh.rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();

    // Loads from memory word 0x12F4_5678
    do_load("lb", 3'b000, 32'h0000_0102, 0, 32'hFFFF_FFF4);
    do_load("lbu", 3'b100, 32'h0000_0102, 2, 32'h0000_00F4);
    do_load("lh", 3'b001, 32'h0000_0100, 0, 32'h0000_5678);
    do_load("lhu", 3'b101, 32'h0000_0102, 1, 32'h0000_12F4);
    do_load("lb3", 3'b000, 32'h0000_0101, 0, 32'h0000_0056);

    // Faults
    do_fault("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
    do_fault("sw_mis", 1'b1, 3'b010, 32'h0000_0102);
    do_fault("ld_f011", 1'b0, 3'b011, 32'h0000_0100);
    do_fault("st_f100", 1'b1, 3'b100, 32'h0000_0100);

    // Back-to-back: store then load held valid
    req(1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344);
    bus.i_dm_aready = 1'b1;
    step();
    chk("b2b.ready0", 32'(bus.o_req_ready), 32'd0);
    chk("b2b.st_avalid", 32'(bus.o_dm_avalid), 32'd1);
    req(1'b0, 3'b010, 32'h0000_0204, 32'h0);
    step();
    chk("b2b.ready1", 32'(bus.o_req_ready), 32'd1);
    chk("b2b.st_rsp", 32'(bus.o_rsp_valid), 32'd1);
    step();
    bus.i_req_valid = 1'b0;
    chk("b2b.ready2", 32'(bus.o_req_ready), 32'd0);
    chk("b2b.ld_avalid", 32'(bus.o_dm_avalid), 32'd1);
    chk("b2b.ld_addr", bus.o_dm_addr, 32'h0000_0204);
    chk("b2b.ld_we", 32'(bus.o_dm_we), 32'd0);
    chk("b2b.no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    step();
    bus.i_dm_aready = 1'b0;
    chk("b2b.rwait_ready", 32'(bus.o_req_ready), 32'd0);
    chk("b2b.rwait_rsp", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_dm_rvalid = 1'b1;
    bus.i_dm_rdata  = 32'hCAFE_F00D;
    step();
    bus.i_dm_rvalid = 1'b0;
    chk("b2b.ld_rsp", 32'(bus.o_rsp_valid), 32'd1);
    chk("b2b.ld_rdata", bus.o_rsp_rdata, 32'hCAFE_F00D);
    chk("b2b.ready3", 32'(bus.o_req_ready), 32'd1);
    step();
    chk("b2b.rsp_single", 32'(bus.o_rsp_valid), 32'd0);

    // Reset while in RWAIT
    req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    bus.i_dm_aready = 1'b1;
    step();
    bus.i_req_valid = 1'b0;
    step();
    bus.i_dm_aready = 1'b0;
    chk("rst_mid.rwait_ready", 32'(bus.o_req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_mid.avalid", 32'(bus.o_dm_avalid), 32'd0);
    chk("rst_mid.rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.i_dm_rvalid = 1'b1;
    bus.i_dm_rdata  = 32'hBAD0_BAD0;
    step();
    bus.i_dm_rvalid = 1'b0;
    chk("rst_mid.stale_rvalid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_mid.idle_ready", 32'(bus.o_req_ready), 32'd1);
    step();
    do_load("lw_after_rst", 3'b010, 32'h0000_0104, 1, 32'h12F4_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage and the data memory bus. It accepts one memory request per transaction from execute: an ALU-computed byte address, the store data, direction and RV32I `funct3` width. It drives a valid/ready address channel plus a read-response channel to data memory, with word-aligned addresses and byte strobes. It returns a sign- or zero-extended load result, or a fault, to the write-back path as a single-cycle response pulse.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.

- `i_clk`  in  1  clock, rising-edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_req_valid`  in  1  execute presents a request.
- `o_req_ready`  out  1  unit can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_req_addr`  in  XLEN  byte address (ALU result).
- `i_req_wdata`  in  XLEN  store data (rs2).
- `o_dm_avalid`  out  1  address-channel valid.
- `i_dm_aready`  in  1  memory accepts the address beat.
- `o_dm_addr`  out  XLEN  word address; bits [1:0] always 0.
- `o_dm_we`  out  1  write enable.
- `o_dm_wstrb`  out  XLEN/8  byte-lane strobes; 0 for loads.
- `o_dm_wdata`  out  XLEN  lane-replicated store data.
- `i_dm_rvalid`  in  1  read data valid.
- `i_dm_rdata`  in  XLEN  read word.
- `o_rsp_valid`  out  1  one-cycle response pulse.
- `o_rsp_rdata`  out  XLEN  extended load data; 0 for stores and faults.
- `o_rsp_fault`  out  1  misaligned address or illegal funct3; qualified by `o_rsp_valid`.

## Operation
- **Reset values.**
  - State is IDLE.
  - `o_req_ready` = 1.
  - All other outputs are 0.
- **FSM states.** IDLE, ADDR, RWAIT.
- **IDLE.**
  - `o_req_ready` = 1.
  - When `i_req_valid` is high, capture we, funct3, addr and wdata into registers.
  - If the request is legal, go to ADDR.
  - If it faults, stay in IDLE and pulse the response.
- **Fault conditions** (no memory access is issued):
  - H/HU with addr[0] = 1.
  - W with addr[1:0] ≠ 00.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- **ADDR.**
  - `o_dm_avalid` = 1.
  - addr, we, wstrb and wdata are driven from the captured registers and stay stable until `i_dm_aready`.
  - On `i_dm_aready`:
    - A store returns to IDLE and pulses the response.
    - A load goes to RWAIT.
- **RWAIT.**
  - On `i_dm_rvalid`, register the extracted, extended data.
  - Return to IDLE and pulse the response.
- **Outside RWAIT.** `i_dm_rvalid` is ignored, including stale beats after a reset.
- **Store lanes.**
  - SB: wdata = 4 copies of wdata[7:0]; wstrb = 0001 << addr[1:0].
  - SH: wdata = 2 copies of wdata[15:0]; wstrb = 0011 << addr[1:0].
  - SW: wdata = wdata; wstrb = 1111.
- **Load extraction.**
  - Shift = rdata >> (8·addr[1:0]).
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- **Response.** No backpressure on the response channel: `o_rsp_valid` is high for exactly one cycle per accepted request.

## Timing
- **Accept.** A request is accepted at rising edge N when `i_req_valid && o_req_ready`.
- **Fault.** `o_rsp_valid` = 1 and `o_rsp_fault` = 1 in cycle N+1. `o_dm_avalid` never rises. `o_req_ready` stays 1.
- **Legal request.**
  - `o_dm_avalid` = 1 from cycle N+1 until the edge where `i_dm_aready` is sampled high.
  - `o_req_ready` = 0 from cycle N+1 until the unit returns to IDLE.
- **Store.** With aready in cycle N+1, `o_rsp_valid` is high in cycle N+2. Each extra aready-low cycle adds one cycle.
- **Load.**
  - RWAIT is entered in cycle N+2.
  - `i_dm_rvalid` high in cycle M (M ≥ N+2) gives `o_rsp_valid` in cycle M+1.
  - Minimum load latency is 3 cycles from accept.
- **Back-to-back requests.** In the response-pulse cycle the state is IDLE, so a new request is accepted on that cycle's edge. Store-to-store throughput is therefore one request per 2 cycles.
- **Reset.** `i_rst_n` low in any state forces IDLE and deasserts `o_dm_avalid` and `o_rsp_valid` immediately, without waiting for a clock edge. An abandoned memory transaction produces no response.

## Test plan
- **SW, immediate aready.** SW addr 0x0000_0100, data 0xDEAD_BEEF, aready high in N+1 → cycle N+1: avalid = 1, addr 0x100, we = 1, wstrb 1111, wdata 0xDEAD_BEEF. Cycle N+2: rsp_valid = 1, fault = 0, rdata = 0.
- **SB, delayed aready.** SB addr 0x0000_0103, data 0x1234_56A5, aready low for 3 cycles → avalid held 4 cycles with addr 0x100, wstrb 1000 and wdata 0xA5A5_A5A5 all stable. Single response pulse one cycle after the aready edge.
- **LB/LBU/LH lane extraction.** Memory returns 0x12F4_5678.
  - LB addr 0x102 → rdata 0xFFFF_FFF4.
  - LBU addr 0x102 → 0x0000_00F4.
  - LH addr 0x100 → 0x0000_5678.
  - In every case rvalid in cycle M gives the response in M+1, and wstrb is 0000.
- **Misaligned and illegal requests.**
  - LH addr 0x101 and SW addr 0x102 → rsp_valid and fault in N+1, avalid stays 0.
  - Load funct3 = 011 → fault.
- **Back-to-back.** Store immediately followed by a load held valid → the load is accepted on the store's response cycle. Ready pattern is 1,0,1,0…; exactly one response per request.
- **Reset mid-load.** Assert rst_n low while in RWAIT → outputs clear asynchronously. A later rvalid in IDLE produces no rsp_valid, and a subsequent LW completes normally.
